// File: rtl/seven_segment_scanner.sv
// Four-digit multiplexed seven-segment scanner with a one-entry shadow buffer.
// New display data is swapped in only at frame boundaries, so a frame never tears.
module seven_segment_scanner (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        enable,
  input  logic [15:0] period,
  input  logic [3:0]  blank_cycles,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  output logic [6:0]  segments,
  output logic        dp,
  output logic [3:0]  digit_en,
  output logic        frame_done
);

  typedef enum logic [1:0] {StIdle, StOn, StBlank} state_e;

  state_e      state_q, state_d;
  logic [1:0]  index_q, index_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] active_digits_q, active_digits_d;
  logic [3:0]  active_dp_q, active_dp_d;
  logic [15:0] shadow_digits_q, shadow_digits_d;
  logic [3:0]  shadow_dp_q, shadow_dp_d;
  logic        shadow_full_q, shadow_full_d;
  logic        frame_done_q, frame_done_d;

  logic [15:0] on_time;
  logic        load_accept;
  logic        enter_frame;
  logic [3:0]  lit_nibble;

  assign on_time     = (period == 16'd0) ? 16'd1 : period;
  assign load_accept = load_valid && !shadow_full_q;

  function automatic logic [6:0] decode_bcd(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  // Slot sequencing and frame-boundary detection.
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    timer_d     = timer_q;
    enter_frame = 1'b0;
    if (!enable) begin
      state_d = StIdle;
      index_d = 2'd0;
      timer_d = 16'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d     = StOn;
          index_d     = 2'd0;
          timer_d     = on_time;
          enter_frame = 1'b1;
        end
        StOn: begin
          if (timer_q <= 16'd1) begin
            if (blank_cycles == 4'd0) begin
              state_d     = StOn;
              index_d     = index_q + 2'd1;
              timer_d     = on_time;
              enter_frame = (index_q == 2'd3);
            end else begin
              state_d = StBlank;
              timer_d = {12'd0, blank_cycles};
            end
          end else begin
            timer_d = timer_q - 16'd1;
          end
        end
        StBlank: begin
          if (timer_q <= 16'd1) begin
            state_d     = StOn;
            index_d     = index_q + 2'd1;
            timer_d     = on_time;
            enter_frame = (index_q == 2'd3);
          end else begin
            timer_d = timer_q - 16'd1;
          end
        end
        default: begin
          state_d = StIdle;
          index_d = 2'd0;
          timer_d = 16'd0;
        end
      endcase
    end
  end

  // Shadow buffer: the swap needs shadow_full, an accept needs it clear, so they never collide.
  always_comb begin
    active_digits_d = active_digits_q;
    active_dp_d     = active_dp_q;
    shadow_digits_d = shadow_digits_q;
    shadow_dp_d     = shadow_dp_q;
    shadow_full_d   = shadow_full_q;
    frame_done_d    = enter_frame;
    if (enter_frame && shadow_full_q) begin
      active_digits_d = shadow_digits_q;
      active_dp_d     = shadow_dp_q;
      shadow_full_d   = 1'b0;
    end
    if (load_accept) begin
      shadow_digits_d = digits_in;
      shadow_dp_d     = dp_in;
      shadow_full_d   = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q         <= StIdle;
      index_q         <= 2'd0;
      timer_q         <= 16'd0;
      active_digits_q <= 16'hFFFF;
      active_dp_q     <= 4'd0;
      shadow_digits_q <= 16'd0;
      shadow_dp_q     <= 4'd0;
      shadow_full_q   <= 1'b0;
      frame_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      index_q         <= index_d;
      timer_q         <= timer_d;
      active_digits_q <= active_digits_d;
      active_dp_q     <= active_dp_d;
      shadow_digits_q <= shadow_digits_d;
      shadow_dp_q     <= shadow_dp_d;
      shadow_full_q   <= shadow_full_d;
      frame_done_q    <= frame_done_d;
    end
  end

  assign lit_nibble = active_digits_q[{index_q, 2'b00} +: 4];

  always_comb begin
    segments = 7'd0;
    dp       = 1'b0;
    digit_en = 4'd0;
    if (state_q == StOn) begin
      segments = decode_bcd(lit_nibble);
      dp       = active_dp_q[index_q];
      digit_en = 4'b0001 << index_q;
    end
  end

  assign load_ready = !shadow_full_q && !wb_rst_i;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner: scan timing, shadow loads, stalls,
// minimum period, non-BCD nibbles, enable drop and mid-frame reset.
module tb_seven_segment_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] period = 16'd0;
  logic [3:0]  blank_cycles = 4'd0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] digits_in = 16'd0;
  logic [3:0]  dp_in = 4'd0;
  logic [6:0]  segments;
  logic        dp;
  logic [3:0]  digit_en;
  logic        frame_done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seven_segment_scanner dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .enable       (enable),
    .period       (period),
    .blank_cycles (blank_cycles),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .digits_in    (digits_in),
    .dp_in        (dp_in),
    .segments     (segments),
    .dp           (dp),
    .digit_en     (digit_en),
    .frame_done   (frame_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] en, input logic [6:0] seg,
                         input logic d, input logic fd);
    chk({tag, " digit_en"}, {12'd0, digit_en}, {12'd0, en});
    chk({tag, " segments"}, {9'd0, segments}, {9'd0, seg});
    chk({tag, " dp"}, {15'd0, dp}, {15'd0, d});
    chk({tag, " frame_done"}, {15'd0, frame_done}, {15'd0, fd});
  endtask

  // Steps through one frame (or its first 'stop' cycles) starting at a boundary edge.
  task automatic frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpv,
                       input int p, input int b, input int stop, input logic rdy0,
                       input int ld_at, input logic [15:0] ld_d, input logic [3:0] ld_p,
                       input int hold_at, input logic [15:0] hd, input logic [3:0] hp);
    logic [6:0] segs [4];
    logic [3:0] en;
    logic [6:0] seg;
    logic       d;
    int         n;
    int         slot;
    int         pos;
    segs[0] = s0;
    segs[1] = s1;
    segs[2] = s2;
    segs[3] = s3;
    n = (stop > 0) ? stop : 4 * (p + b);
    for (int c = 0; c < n; c++) begin
      step();
      slot = c / (p + b);
      pos  = c % (p + b);
      if (pos < p) begin
        en  = 4'b0001 << slot;
        seg = segs[slot];
        d   = dpv[slot];
      end else begin
        en  = 4'd0;
        seg = 7'd0;
        d   = 1'b0;
      end
      chk_out($sformatf("%s c%0d", tag, c), en, seg, d, (c == 0));
      if (c == 0) chk($sformatf("%s c0 load_ready", tag), {15'd0, load_ready}, {15'd0, rdy0});
      if (ld_at >= 0 && c == ld_at + 1) begin
        chk($sformatf("%s c%0d load_ready", tag, c), {15'd0, load_ready}, 16'd0);
        load_valid = 1'b0;
      end
      if (c == ld_at) begin
        load_valid = 1'b1;
        digits_in  = ld_d;
        dp_in      = ld_p;
      end
      if (c == hold_at) begin
        load_valid = 1'b1;
        digits_in  = hd;
        dp_in      = hp;
      end
    end
  endtask

  initial begin
    step();
    step();
    chk_out("in_reset", 4'd0, 7'd0, 1'b0, 1'b0);
    chk("in_reset load_ready", {15'd0, load_ready}, 16'd0);
    rst = 1'b0;
    #1;
    chk("post_reset load_ready", {15'd0, load_ready}, 16'd1);
    chk_out("post_reset", 4'd0, 7'd0, 1'b0, 1'b0);

    // Load 0x4321 while idle, then start scanning.
    period       = 16'd3;
    blank_cycles = 4'd1;
    digits_in    = 16'h4321;
    dp_in        = 4'b0001;
    load_valid   = 1'b1;
    step();
    chk("idle_load load_ready", {15'd0, load_ready}, 16'd0);
    chk("idle_load digit_en", {12'd0, digit_en}, 16'd0);
    load_valid = 1'b0;
    enable     = 1'b1;

    frame("f1_4321", 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110, 4'b0001, 3, 1, 0,
          1'b1, 5, 16'h9876, 4'b1010, -1, 16'h0, 4'h0);
    frame("f2_9876", 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111, 4'b1010, 3, 1, 0,
          1'b1, 2, 16'h0123, 4'b1000, 8, 16'hC5A0, 4'b0110);
    frame("f3_0123", 7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111, 4'b1000, 3, 1, 0,
          1'b1, 0, 16'hC5A0, 4'b0110, -1, 16'h0, 4'h0);
    frame("f4_c5a0", 7'b0111111, 7'b0000000, 7'b1101101, 7'b0000000, 4'b0110, 3, 1, 0,
          1'b1, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    period       = 16'd0;
    blank_cycles = 4'd0;
    frame("f5a_p0", 7'b0111111, 7'b0000000, 7'b1101101, 7'b0000000, 4'b0110, 1, 0, 0,
          1'b1, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    frame("f5b_p0", 7'b0111111, 7'b0000000, 7'b1101101, 7'b0000000, 4'b0110, 1, 0, 0,
          1'b1, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    period = 16'd2;
    frame("f6_p2", 7'b0111111, 7'b0000000, 7'b1101101, 7'b0000000, 4'b0110, 2, 0, 5,
          1'b1, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    // Drop enable while digit 2 is lit.
    enable = 1'b0;
    step();
    chk_out("disable", 4'd0, 7'd0, 1'b0, 1'b0);
    step();
    chk_out("idle_hold", 4'd0, 7'd0, 1'b0, 1'b0);
    enable = 1'b1;
    step();
    chk_out("reenable", 4'b0001, 7'b0111111, 1'b0, 1'b1);

    // Fill the shadow, then reset mid-frame: shadow must be discarded.
    load_valid = 1'b1;
    digits_in  = 16'h2222;
    dp_in      = 4'b1111;
    step();
    chk("pre_reset load_ready", {15'd0, load_ready}, 16'd0);
    chk_out("pre_reset", 4'b0001, 7'b0111111, 1'b0, 1'b0);
    load_valid = 1'b0;
    rst        = 1'b1;
    step();
    chk_out("mid_reset", 4'd0, 7'd0, 1'b0, 1'b0);
    chk("mid_reset load_ready", {15'd0, load_ready}, 16'd0);
    rst = 1'b0;
    #1;
    chk("reset_release load_ready", {15'd0, load_ready}, 16'd1);
    step();
    chk_out("after_reset_frame", 4'b0001, 7'b0000000, 1'b0, 1'b1);
    chk("after_reset load_ready", {15'd0, load_ready}, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: wb_clk_i and wb_rst_i.
REQ-002 wb_clk_i  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 wb_rst_i  input  1  synchronous active-high reset.
REQ-004 enable  input  1  high = scan display; low = blank display.
REQ-005 period  input  16  on-time per digit in cycles; value 0 SHALL be treated as 1.
REQ-006 blank_cycles  input  4  dark gap after each digit slot, in cycles (0 = no gap).
REQ-007 load_valid  input  1  new display data offered.
REQ-008 load_ready  output  1  high = shadow buffer empty, so a load can be accepted.
REQ-009 digits_in  input  16  four BCD nibbles; bits [3:0] = digit 0.
REQ-010 dp_in  input  4  decimal point per digit; bit n = digit n.
REQ-011 segments  output  7  segment drive, bit order gfedcba, active-high.
REQ-012 dp  output  1  decimal point of the lit digit.
REQ-013 digit_en  output  4  one-hot, active-high digit select.
REQ-014 frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-015 The FSM SHALL have three states:
- IDLE
- ON: one digit lit.
- BLANK: all digits dark.
REQ-016 Registered state SHALL comprise:
- FSM state
- 2-bit digit index
- 16-bit slot timer
- active digit/dp registers (16+4 bits)
- shadow digit/dp registers (16+4 bits)
- shadow_full flag
REQ-017 segments, dp and digit_en SHALL be combinational decodes of registered state only (no input-to-output path).
REQ-018 In ON, digit_en SHALL equal 1<<index, segments SHALL equal decode(active nibble[index]), and dp SHALL equal active dp[index].
REQ-019 In IDLE and BLANK, digit_en, segments and dp SHALL all be 0.
REQ-020 Decode table: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111; nibbles 10-15 SHALL decode to 0000000.
REQ-021 IDLE->ON (index 0) SHALL occur on the first edge where enable=1.
REQ-022 On every entry to ON, the timer SHALL load max(period,1) as sampled that edge, so ON lasts exactly that many cycles.
REQ-023 When the ON timer expires:
- blank_cycles=0: go to ON with index+1 (mod 4).
- otherwise: go to BLANK for exactly blank_cycles cycles (sampled at BLANK entry), then ON with index+1 (mod 4).
REQ-024 Frame boundary = any edge on which the FSM enters ON with index 0, including from IDLE; the boundary SHALL assert frame_done for the following cycle.
REQ-025 At a frame boundary with shadow_full=1, shadow SHALL copy to active and shadow_full SHALL clear on the same edge, so digit 0 shows the new data in its first lit cycle.
REQ-026 Frame length SHALL be 4*(max(period,1)+blank_cycles) cycles.
REQ-027 load_ready SHALL equal !shadow_full && !wb_rst_i.
REQ-028 A load is accepted when load_valid && load_ready on an edge: digits_in/dp_in SHALL be written to shadow and shadow_full SHALL be set.
REQ-029 A load accepted on a frame-boundary edge with the shadow empty SHALL go to shadow and be displayed from the next frame.
REQ-030 When load_valid is high while shadow_full=1, the load SHALL be stalled; no data is lost or overwritten.
REQ-031 Loads SHALL be accepted in every state, including IDLE.
REQ-032 enable=0 in any state SHALL force IDLE with index 0 on the next edge.
REQ-033 Dropping enable SHALL preserve active, shadow and shadow_full; re-enable SHALL begin a new frame per REQ-021/024.
REQ-034 Changes to period or blank_cycles SHALL take effect only at the next slot or blank entry.

Reset
REQ-035 While wb_rst_i=1 at an edge, reset SHALL take priority over all other inputs and SHALL set:
- state IDLE, index 0, timer 0
- active digits 0xFFFF, active dp 0
- shadow 0, shadow_full 0, frame_done 0
REQ-036 Outputs after reset: segments 0, dp 0, digit_en 0, load_ready 1 from the first cycle with wb_rst_i=0.
REQ-037 Reset asserted mid-frame SHALL take effect on the next edge and discard any shadow contents.

Verification
REQ-038 Reset, period=3, blank=1, load 0x4321 dp=0001, enable=1 -> segments sequence:
- digit_en 0001 seg 0000110 dp=1 for 3 cycles
- 1 dark cycle
- 0010 seg 1011011, 0100 seg 1001111, 1000 seg 1100110
- frame_done pulses every 16 cycles.
REQ-039 Load 0x9876 mid-frame -> load_ready drops next cycle; the current frame is unchanged; the next frame shows 6,7,8,9 and load_ready returns to 1 after the boundary.
REQ-040 Shadow full plus load_valid held -> no accept until after the boundary; the second value is displayed exactly one frame later.
REQ-041 period=0, blank=0 -> digit_en rotates every cycle (0001,0010,0100,1000) with no dark cycles; frame_done every 4 cycles.
REQ-042 Nibble 0xA-0xF -> segments 0000000 while digit_en is still asserted.
REQ-043 enable dropped while index=2 -> all outputs 0 next cycle; re-enable -> digit 0 is lit with frame_done; wb_rst_i mid-frame -> REQ-035 values next cycle.
